// File: rtl/hit_pkg.sv
// -----------------------------------------------------------------------------
// hit_pkg
// Shared types and helpers for the sprite-layer collision detector.
//   hit_mode_t   : pulse qualification mode (once per frame / once per edge)
//   hit_event_t  : default event record {rules, x, y} for the event FIFO
//   rule_slice() : extracts one rule's object set from a flattened mask vector
// -----------------------------------------------------------------------------
package hit_pkg;

  typedef enum logic {
    HIT_PER_FRAME = 1'b0,
    HIT_PER_EDGE  = 1'b1
  } hit_mode_t;

  // Default event record geometry (matches the detector's default parameters).
  localparam int HIT_EVT_RULES_W = 8;
  localparam int HIT_EVT_COORD_W = 11;

  typedef struct packed {
    logic [HIT_EVT_RULES_W-1:0] rules;
    logic [HIT_EVT_COORD_W-1:0] x;
    logic [HIT_EVT_COORD_W-1:0] y;
  } hit_event_t;

  // Upper bounds used by rule_slice(); a detector instance must stay within
  // HIT_MAX_OBJ objects and HIT_MAX_RULES rules.
  localparam int HIT_MAX_OBJ   = 32;
  localparam int HIT_MAX_RULES = 32;
  localparam int HIT_MASK_W    = HIT_MAX_OBJ * HIT_MAX_RULES;

  // Returns the n_obj-bit object set of rule rule_idx from a flattened mask
  // vector laid out as [rule_idx*n_obj +: n_obj], zero-extended to HIT_MAX_OBJ.
  function automatic logic [HIT_MAX_OBJ-1:0] rule_slice(
    input logic [HIT_MASK_W-1:0] masks,
    input int                    rule_idx,
    input int                    n_obj
  );
    logic [HIT_MAX_OBJ-1:0] keep;
    for (int i = 0; i < HIT_MAX_OBJ; i++) begin
      keep[i] = (i < n_obj);
    end
    return HIT_MAX_OBJ'(masks >> (rule_idx * n_obj)) & keep;
  endfunction

endpackage

// File: rtl/hit_event_fifo.sv
// -----------------------------------------------------------------------------
// hit_event_fifo
// Synchronous first-word-fall-through FIFO for collision event records.
// The head entry is held in a register so it stays stable (last value) while
// the FIFO is empty; storage is a plain array with one write and one
// registered read port.
// Ports:
//   clk, resetN        : clock, asynchronous active-low reset
//   i_push, i_data     : write request and record (accepted if not full, or
//                        if a pop happens in the same cycle)
//   o_full             : all DEPTH entries occupied
//   i_pop              : consume head entry (ignored while empty)
//   o_empty            : no entry queued
//   o_head             : current head entry (valid when !o_empty)
// -----------------------------------------------------------------------------
module hit_event_fifo
  import hit_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = hit_event_t
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_push,
  input  T     i_data,
  output logic o_full,
  input  logic i_pop,
  output logic o_empty,
  output T     o_head
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T           r_head;

  logic        w_push_ok;
  logic        w_pop_ok;
  logic [AW:0] w_wr_next;
  logic [AW:0] w_rd_next;

  // Extra MSB on each pointer distinguishes full from empty.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign w_wr_next = r_wr_ptr + (AW+1)'(w_push_ok);
  assign w_rd_next = r_rd_ptr + (AW+1)'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      // Refresh the head only when something will be queued afterwards; the
      // entry being written this cycle is not in the array yet, so bypass it.
      if (w_wr_next != w_rd_next) begin
        if (w_push_ok && (w_rd_next[AW-1:0] == r_wr_ptr[AW-1:0])) begin
          r_head <= i_data;
        end else begin
          r_head <= mem[w_rd_next[AW-1:0]];
        end
      end
    end
  end

  assign o_head = r_head;

endmodule

// File: rtl/collision_matrix.sv
// -----------------------------------------------------------------------------
// collision_matrix
// Rule-based collision detector for the sprite layer. Each rule pairs an
// A object set with a B object set; a rule matches when at least one object
// of each set is drawing the current pixel. Matches are qualified into hit
// pulses (once per frame, or once per rising match edge) and every pulsing
// cycle queues one event record {rules, x, y} for game logic.
// Ports:
//   clk, resetN               : clock, asynchronous active-low reset
//   startOfFrame              : one-cycle frame start pulse
//   hit_request[NUM_OBJECTS]  : per-object drawing request for this pixel
//   pixelX, pixelY            : current pixel coordinate
//   rule_enable[NUM_RULES]    : runtime per-rule enable
//   collision[NUM_RULES]      : registered raw match
//   hit_pulse[NUM_RULES]      : registered qualified hit
//   evt_valid / evt_ready     : event FIFO head handshake
//   evt_rules, evt_x, evt_y   : head event record
//   evt_overflow              : sticky, an event was dropped this frame
// -----------------------------------------------------------------------------
module collision_matrix
  import hit_pkg::*;
#(
  parameter int                               NUM_OBJECTS = 8,
  parameter int                               NUM_RULES   = 8,
  parameter logic [NUM_RULES*NUM_OBJECTS-1:0] RULE_A_MASK = '0,
  parameter logic [NUM_RULES*NUM_OBJECTS-1:0] RULE_B_MASK = '0,
  parameter hit_mode_t                        MODE        = HIT_PER_FRAME,
  parameter int                               FIFO_DEPTH  = 8,
  parameter int                               COORD_W     = 11
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [NUM_OBJECTS-1:0] hit_request,
  input  logic [COORD_W-1:0]     pixelX,
  input  logic [COORD_W-1:0]     pixelY,
  input  logic [NUM_RULES-1:0]   rule_enable,
  output logic [NUM_RULES-1:0]   collision,
  output logic [NUM_RULES-1:0]   hit_pulse,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [NUM_RULES-1:0]   evt_rules,
  output logic [COORD_W-1:0]     evt_x,
  output logic [COORD_W-1:0]     evt_y,
  output logic                   evt_overflow
);

  typedef struct packed {
    logic [NUM_RULES-1:0] rules;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
  } evt_t;

  localparam logic [HIT_MASK_W-1:0] A_MASKS = HIT_MASK_W'(RULE_A_MASK);
  localparam logic [HIT_MASK_W-1:0] B_MASKS = HIT_MASK_W'(RULE_B_MASK);

  logic [HIT_MAX_OBJ-1:0] w_req_ext;
  logic [NUM_RULES-1:0]   w_match;
  logic [NUM_RULES-1:0]   w_pulse_next;

  logic [NUM_RULES-1:0]   r_collision;
  logic [NUM_RULES-1:0]   r_hit_pulse;
  logic [COORD_W-1:0]     r_px;
  logic [COORD_W-1:0]     r_py;
  logic                   r_overflow;

  evt_t w_push_data;
  evt_t w_head;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  assign w_req_ext = HIT_MAX_OBJ'(hit_request);

  // Raw per-rule match; the object sets are elaboration-time constants.
  generate
    for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
      localparam logic [HIT_MAX_OBJ-1:0] A_SET = rule_slice(A_MASKS, gi, NUM_OBJECTS);
      localparam logic [HIT_MAX_OBJ-1:0] B_SET = rule_slice(B_MASKS, gi, NUM_OBJECTS);
      assign w_match[gi] = rule_enable[gi] &&
                           (|(w_req_ext & A_SET)) &&
                           (|(w_req_ext & B_SET));
    end
  endgenerate

  // Pulse qualification.
  generate
    if (MODE == HIT_PER_FRAME) begin : g_frame
      logic [NUM_RULES-1:0] r_flag;
      logic [NUM_RULES-1:0] w_eff_flag;

      // A frame start wipes the fired flags before this cycle's match is
      // considered, so a coinciding match counts in the new frame.
      assign w_eff_flag   = startOfFrame ? '0 : r_flag;
      assign w_pulse_next = w_match & ~w_eff_flag;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          r_flag <= '0;
        end else begin
          r_flag <= w_eff_flag | w_match;
        end
      end
    end else begin : g_edge
      logic [NUM_RULES-1:0] r_prev_match;

      assign w_pulse_next = w_match & ~r_prev_match;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          r_prev_match <= '0;
        end else begin
          r_prev_match <= w_match;
        end
      end
    end
  endgenerate

  // The event is built from the registered pulse vector and the coordinate
  // captured alongside it, so it enters the FIFO one cycle after hit_pulse.
  assign w_push      = |r_hit_pulse;
  assign w_pop       = !w_empty && evt_ready;
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_push_data = '{rules: r_hit_pulse, x: r_px, y: r_py};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_collision <= '0;
      r_hit_pulse <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_collision <= w_match;
      r_hit_pulse <= w_pulse_next;
      r_px        <= pixelX;
      r_py        <= pixelY;
      // A drop wins over the frame-start clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (startOfFrame) begin
        r_overflow <= 1'b0;
      end
    end
  end

  hit_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign collision    = r_collision;
  assign hit_pulse    = r_hit_pulse;
  assign evt_valid    = !w_empty;
  assign evt_rules    = w_head.rules;
  assign evt_x        = w_head.x;
  assign evt_y        = w_head.y;
  assign evt_overflow = r_overflow;

endmodule

// File: doc/collision_matrix.md
# collision_matrix

Parametrised collision detector for the sprite layer. Each clock it matches per-pixel object hit requests against a configurable set of rules, where a rule is an A-object-set versus a B-object-set. For each rule it issues at most one hit pulse per frame, or one pulse per rising match edge in edge mode. Every cycle that produces a pulse also queues an event record (rule mask plus pixel coordinate) into a small FIFO, which game logic drains with a valid/ready handshake. It sits between the drawing-request mux and the game-control / scoring blocks.

## Interface
Parameters:
- NUM_OBJECTS, 8: number of drawing-request inputs.
- NUM_RULES, 8: number of collision rules.
- RULE_A_MASK, 0: NUM_RULES*NUM_OBJECTS bits; rule r's A set is bits [r*NUM_OBJECTS +: NUM_OBJECTS].
- RULE_B_MASK, 0: same layout; rule r's B set.
- MODE, HIT_PER_FRAME: HIT_PER_FRAME or HIT_PER_EDGE (hit_pkg::hit_mode_t).
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two, ≥2.
- COORD_W, 11: pixel coordinate width.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- hit_request  in  NUM_OBJECTS  per-object drawing request for the current pixel.
- pixelX, pixelY  in  COORD_W each  current pixel coordinate.
- rule_enable  in  NUM_RULES  runtime per-rule enable.
- collision  out  NUM_RULES  registered raw match.
- hit_pulse  out  NUM_RULES  one-cycle qualified hit.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_rules  out  NUM_RULES  head entry: hit_pulse vector.
- evt_x, evt_y  out  COORD_W each  head entry: pixel coordinate.
- evt_overflow  out  1  sticky flag: an event was dropped.

## Operation
- match[r] = rule_enable[r] && |(hit_request & A_r) && |(hit_request & B_r). The logic is combinational.
- collision <= match on every clock.
- HIT_PER_FRAME mode:
  - A per-rule flag register marks rules that have already fired this frame.
  - hit_pulse[r] <= match[r] && !eff_flag[r].
  - eff_flag = startOfFrame ? 0 : flag.
  - flag <= eff_flag | match.
- HIT_PER_EDGE mode:
  - hit_pulse[r] <= match[r] && !prev_match[r].
  - prev_match <= match.
  - startOfFrame has no effect on pulses in this mode.
- Event push: when match-qualified pulses are non-zero, write one entry {pulse vector, pixelX, pixelY} from the same cycle. Only one push happens per cycle, whatever the number of rules.
- Pop: when evt_valid && evt_ready.
- Full FIFO:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the push is dropped and evt_overflow is set to 1.
- evt_overflow clears on startOfFrame, unless a drop occurs in that same cycle, in which case it stays 1.
- Empty FIFO: evt_valid = 0, and the evt_* data outputs hold their last value. A simultaneous push and pop on an empty FIFO is impossible, because the pop requires valid.

## Timing
- Reset clears every output and internal register to 0: collision, hit_pulse, flags, prev_match, FIFO pointers, and evt_overflow. evt_valid = 0 and evt_rules/evt_x/evt_y = 0.
- collision and hit_pulse have 1-cycle latency from hit_request.
- An event is visible on evt_valid 1 cycle after its hit_pulse cycle (2 cycles after the request).
- The FIFO is first-word-fall-through: the head entry is valid whenever evt_valid = 1.
- A startOfFrame coinciding with a match counts the match in the new frame: the pulse fires and the flag is set.
- Reset asserted mid-frame or mid-burst discards all queued events.

## Structure
- hit_pkg holds:
  - hit_mode_t enum.
  - hit_event_t struct {rules, x, y}, parameterised via localparams.
  - A helper function rule_slice() that extracts a rule's mask.
- Sub-module hit_event_fifo: synchronous FWFT FIFO of hit_event_t with push/full/pop/empty. Depth is a parameter; pointers are log2(DEPTH)+1 bits.

## Test plan
- Rule 0 (A={1}, B={2}), HIT_PER_FRAME: hit_request=3'b110 for 5 cycles -> collision[0] high for 5 cycles; hit_pulse[0] high only in cycle 1; exactly one event, with the coordinate of the first pixel.
- startOfFrame in the same cycle as a repeated match -> a second hit_pulse[0] and a second event.
- HIT_PER_EDGE: match pattern 1,1,0,1 -> pulses on cycles 1 and 4 only.
- Rules 0 and 3 match in the same cycle -> one event with evt_rules=8'b0000_1001.
- FIFO_DEPTH=4, evt_ready=0, 6 distinct hits:
  - 4 entries queued and evt_overflow=1.
  - After draining with ready=1, the 4 entries come out in order.
  - evt_overflow then clears at the next startOfFrame.
- rule_enable[0]=0 during a match -> no collision, no pulse, no event. Reset asserted while 3 entries are queued -> evt_valid=0 immediately.
